// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg
// Shared constants and state encoding for the UART command bridge.
// Contents:
//   SYNC_DEFAULT          default frame start marker
//   OP_WRITE / OP_READ    command opcodes ('W' / 'R')
//   RSP_OK / RSP_ERR      response codes ('K' / 'E')
//   state_t               bridge FSM state encoding
package uart_bridge_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_EXEC,
    ST_RDWAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge
// Turns framed byte commands from a UART receiver into single register
// accesses and returns one response byte to the UART transmitter.
// Frame: SYNC, opcode ('W' or 'R'), address, [write data].
// Ports:
//   CLK, rst            clock, asynchronous active-high reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   tx_data, tx_valid   response byte, held until tx_ready
//   tx_ready            transmitter accepts the byte
//   reg_addr, reg_wdata register address / write data (held between frames)
//   reg_we, reg_re      one-cycle register write / read strobes
//   reg_rdata           read data, valid the cycle after reg_re
//   busy                high whenever a frame or response is in progress
//   rx_drop             pulse when a byte arrives while it cannot be taken
module uart_cmd_bridge
  import uart_bridge_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       rx_drop
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  // Last counter value before the idle limit is reached; one more empty
  // cycle from here abandons the frame.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       reg_addr_q, reg_addr_d;
  logic [7:0]       reg_wdata_q, reg_wdata_d;
  logic             reg_we_q, reg_we_d;
  logic             reg_re_q, reg_re_d;
  logic             busy_q, busy_d;
  logic             rx_drop_q, rx_drop_d;
  logic             byte_phase;

  // Next-state logic. Every output is a flop, so strobes are set on the edge
  // that enters the state in which they must be visible (reg_we/reg_re are
  // high during EXEC, tx_valid during RESP).
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    cnt_d       = '0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    rx_drop_d   = 1'b0;
    byte_phase  = state_q inside {ST_CMD, ST_ADDR, ST_DATA};

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (rx_valid) begin
          if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
            is_wr_d = (rx_data == OP_WRITE);
            state_d = ST_ADDR;
          end else begin
            tx_data_d  = RSP_ERR;
            tx_valid_d = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          reg_addr_d = rx_data;
          if (is_wr_q) begin
            state_d = ST_DATA;
          end else begin
            reg_re_d = 1'b1;
            state_d  = ST_EXEC;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          reg_wdata_d = rx_data;
          reg_we_d    = 1'b1;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_wr_q) begin
          tx_data_d  = RSP_OK;
          tx_valid_d = 1'b1;
          state_d    = ST_RESP;
        end else begin
          state_d = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        tx_data_d  = reg_rdata;
        tx_valid_d = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    // Inter-byte idle timer. An arriving byte leaves cnt_d at zero and wins
    // over an expiring count; the counter stops at the limit and never wraps.
    if (byte_phase && !rx_valid) begin
      if (cnt_q >= CNT_LAST) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    rx_drop_d = rx_valid && (state_q inside {ST_EXEC, ST_RDWAIT, ST_RESP});
    busy_d    = (state_d != ST_IDLE);
  end

  // Single state/output register bank with asynchronous reset.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      is_wr_q     <= 1'b0;
      cnt_q       <= '0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      rx_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
      rx_drop_q   <= rx_drop_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;
  assign rx_drop   = rx_drop_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge
// Self-checking bench for uart_cmd_bridge. Directed frames cover write,
// read, bad opcode, idle timeout, stalled response with dropped bytes and
// reset mid-frame; a random phase checks frames against a frame-level
// register-file model.
module tb_uart_cmd_bridge;

  localparam int TIMEOUT = 50;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       rx_drop;

  uart_cmd_bridge #(
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .CLK      (CLK),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy),
    .rx_drop  (rx_drop)
  );

  // Free-running clock and cycle counter used to measure latencies.
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Register file the bridge talks to. Read data is only meaningful in the
  // cycle after reg_re; every other cycle it carries junk.
  logic [7:0] mem [256];
  always @(posedge CLK) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    reg_rdata <= reg_re ? mem[reg_addr] : 8'($urandom);
  end

  // Event monitor, sampling on the falling edge. Counters are cumulative;
  // the stimulus takes a baseline before each frame and checks deltas.
  int weCount = 0, reCount = 0, dropCount = 0, txRiseCount = 0, txUnstable = 0;
  int lastWeCyc = -1, lastReCyc = -1, txRiseCyc = -1, hsCyc = -1, busyFallCyc = -1;
  logic [15:0] weQ[$];
  logic [7:0]  txQ[$];
  logic        prevTxValid = 1'b0;
  logic        prevBusy = 1'b0;
  logic [7:0]  prevTxData = 8'h00;

  always @(negedge CLK) begin
    if (reg_we) begin
      weCount++;
      weQ.push_back({reg_addr, reg_wdata});
      lastWeCyc = cyc;
    end
    if (reg_re) begin
      reCount++;
      lastReCyc = cyc;
    end
    if (rx_drop) dropCount++;
    if (tx_valid && !prevTxValid) begin
      txRiseCount++;
      txRiseCyc = cyc;
    end
    if (tx_valid && prevTxValid && (tx_data != prevTxData)) txUnstable++;
    if (tx_valid && tx_ready) begin
      txQ.push_back(tx_data);
      hsCyc = cyc;
    end
    if (prevBusy && !busy) busyFallCyc = cyc;
    prevTxValid = tx_valid;
    prevTxData  = tx_data;
    prevBusy    = busy;
  end

  // Frame-level reference: what the register file should contain.
  logic [7:0] refMem [256];

  int vectors = 0;
  int miscompares = 0;
  int lastDrive = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Drives one byte for exactly one cycle; callers sit just after a rising edge.
  task automatic sendByte(input logic [7:0] b);
    rx_data   = b;
    rx_valid  = 1'b1;
    lastDrive = cyc;
    tick();
    rx_valid  = 1'b0;
  endtask

  task automatic waitTxRise(input int base);
    int g = 0;
    while (txRiseCount == base && g < 12) begin
      tick();
      g++;
    end
  endtask

  task automatic waitHandshake(input int base);
    int g = 0;
    while (txQ.size() == base && g < 12) begin
      tick();
      g++;
    end
  endtask

  function automatic logic [31:0] txAt(input int idx);
    return (txQ.size() > idx) ? 32'(txQ[idx]) : 32'hDEAD_BEEF;
  endfunction

  // Sends one complete frame (optionally preceded by idle-state noise) and
  // checks response byte, strobes and latencies against the model.
  task automatic applyStimulus(input string tag, input logic [7:0] op,
                               input logic [7:0] a, input logic [7:0] d,
                               input int gapMin, input int gapMax,
                               input int noiseMax, input int readyDelay);
    int weBase = weCount, reBase = reCount, dropBase = dropCount;
    int txBase = txQ.size(), riseBase = txRiseCount, unstBase = txUnstable;
    int lastByte, raiseCyc, expLat, expHs;
    bit isW = (op == 8'h57);
    bit isR = (op == 8'h52);
    logic [7:0] expTx, nb;

    expTx  = isW ? 8'h4B : (isR ? refMem[a] : 8'h45);
    expLat = isW ? 2 : (isR ? 3 : 1);
    tx_ready = (readyDelay == 0);

    repeat ($urandom_range(noiseMax, 0)) begin
      nb = 8'($urandom);
      if (nb == 8'hA5) nb = 8'h5A;
      sendByte(nb);
    end
    sendByte(8'hA5);
    idle($urandom_range(gapMax, gapMin));
    sendByte(op);
    if (isW || isR) begin
      idle($urandom_range(gapMax, gapMin));
      sendByte(a);
    end
    if (isW) begin
      idle($urandom_range(gapMax, gapMin));
      sendByte(d);
    end
    lastByte = lastDrive;
    expHs = lastByte + expLat;

    waitTxRise(riseBase);
    if (readyDelay > 0) begin
      idle(readyDelay);
      tx_ready = 1'b1;
      raiseCyc = cyc;
      expHs = raiseCyc;
    end
    waitHandshake(txBase);
    tx_ready = 1'b0;
    if (isW) refMem[a] = d;

    checkOutput({tag, " tx byte"}, txAt(txBase), 32'(expTx));
    checkOutput({tag, " tx count"}, txQ.size() - txBase, 1);
    checkOutput({tag, " tx latency"}, txRiseCyc - lastByte, expLat);
    checkOutput({tag, " handshake cycle"}, hsCyc, expHs);
    checkOutput({tag, " we count"}, weCount - weBase, 32'(isW));
    checkOutput({tag, " re count"}, reCount - reBase, 32'(isR));
    if (isW) begin
      checkOutput({tag, " we addr/data"},
                  (weQ.size() > weBase) ? 32'(weQ[weBase]) : 32'hDEAD_BEEF,
                  32'({a, d}));
      checkOutput({tag, " we latency"}, lastWeCyc - lastByte, 1);
    end
    if (isR) checkOutput({tag, " re latency"}, lastReCyc - lastByte, 1);
    checkOutput({tag, " drops"}, dropCount - dropBase, 0);
    checkOutput({tag, " tx stable"}, txUnstable - unstBase, 0);
    checkOutput({tag, " idle after"}, {busy, tx_valid}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int weBase, txBase, riseBase, dropBase, unstBase, lastByte, raiseCyc, fallDelta;
    logic [7:0] op, a;

    // Reset values while reset is held.
    idle(3);
    checkOutput("reset strobes", {tx_valid, reg_we, reg_re, busy, rx_drop}, 5'b0);
    checkOutput("reset data", {tx_data, reg_addr, reg_wdata}, 24'h0);
    rst = 1'b0;

    $display("[TB] directed frames");
    applyStimulus("write 10<-3C", 8'h57, 8'h10, 8'h3C, 0, 0, 0, 3);
    applyStimulus("write 20<-9E", 8'h57, 8'h20, 8'h9E, 0, 2, 1, 0);
    applyStimulus("read 20", 8'h52, 8'h20, 8'h00, 0, 0, 0, 2);
    applyStimulus("bad op 58", 8'h58, 8'h00, 8'h00, 0, 0, 0, 4);
    applyStimulus("sync as addr/data", 8'h57, 8'hA5, 8'hA5, 0, 1, 0, 0);
    applyStimulus("read A5", 8'h52, 8'hA5, 8'h00, 0, 0, 0, 1);
    applyStimulus("gap 49 accepted", 8'h57, 8'h11, 8'h22, 49, 49, 0, 1);

    // Idle timeout: frame abandoned without access or response.
    $display("[TB] timeout");
    weBase = weCount; txBase = txQ.size(); riseBase = txRiseCount;
    tx_ready = 1'b1;
    sendByte(8'hA5);
    sendByte(8'h57);
    lastByte = lastDrive;
    idle(60);
    tx_ready = 1'b0;
    fallDelta = busyFallCyc - lastByte;
    checkOutput("timeout busy fall", 32'(fallDelta >= TIMEOUT && fallDelta <= TIMEOUT + 1), 1);
    checkOutput("timeout busy now", busy, 1'b0);
    checkOutput("timeout no we", weCount - weBase, 0);
    checkOutput("timeout no tx", txRiseCount - riseBase, 0);
    checkOutput("timeout no handshake", txQ.size() - txBase, 0);

    // Stalled response with bytes arriving meanwhile.
    $display("[TB] stalled response");
    weBase = weCount; txBase = txQ.size(); riseBase = txRiseCount;
    dropBase = dropCount; unstBase = txUnstable;
    sendByte(8'hA5);
    sendByte(8'h57);
    sendByte(8'h30);
    sendByte(8'hC4);
    waitTxRise(riseBase);
    idle(10);
    sendByte(8'hA5);
    idle(40);
    sendByte(8'h52);
    idle(47);
    checkOutput("stall still pending", {busy, tx_valid}, 2'b11);
    tx_ready = 1'b1;
    raiseCyc = cyc;
    waitHandshake(txBase);
    tx_ready = 1'b0;
    refMem[8'h30] = 8'hC4;
    checkOutput("stall drops", dropCount - dropBase, 2);
    checkOutput("stall tx stable", txUnstable - unstBase, 0);
    checkOutput("stall tx byte", txAt(txBase), 32'h4B);
    checkOutput("stall handshake cycle", hsCyc, raiseCyc);
    checkOutput("stall we count", weCount - weBase, 1);
    checkOutput("stall idle after", {busy, tx_valid}, 2'b00);

    // Reset while a read response is pending.
    $display("[TB] reset mid-response");
    txBase = txQ.size(); riseBase = txRiseCount;
    sendByte(8'hA5);
    sendByte(8'h52);
    sendByte(8'h03);
    waitTxRise(riseBase);
    tick();
    rst = 1'b1;
    #2;
    checkOutput("async reset outputs", {tx_valid, busy, reg_re, reg_we}, 4'b0);
    idle(2);
    rst = 1'b0;
    checkOutput("reset no handshake", txQ.size() - txBase, 0);

    // Reset between ADDR and DATA of a write, then an immediate new frame.
    $display("[TB] reset mid-frame");
    weBase = weCount;
    sendByte(8'hA5);
    sendByte(8'h57);
    sendByte(8'h44);
    tick();
    rst = 1'b1;
    #2;
    checkOutput("mid-frame reset addr", reg_addr, 8'h00);
    idle(2);
    rst = 1'b0;
    checkOutput("mid-frame no we", weCount - weBase, 0);
    applyStimulus("write after reset", 8'h57, 8'h44, 8'h77, 0, 0, 0, 1);

    // Random frames against the register-file model; addresses 0..7 are
    // written first so every later read has a known value.
    $display("[TB] random frames");
    for (int i = 0; i < 8; i++) begin
      applyStimulus("init write", 8'h57, 8'(i), 8'($urandom), 0, 3, 2,
                    $urandom_range(3, 0));
    end
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(2, 0))
        0: op = 8'h57;
        1: op = 8'h52;
        default: begin
          op = 8'($urandom);
          if (op == 8'h57 || op == 8'h52) op = 8'h00;
        end
      endcase
      a = 8'($urandom_range(7, 0));
      applyStimulus("random frame", op, a, 8'($urandom), 0, 3, 2,
                    $urandom_range(3, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
